// File: rtl/exposure_controller_if.sv
// Signal bundle between an exposure controller and its host: frame/exposure
// commands in one direction, pixel-array timing strobes and status in the other.
interface exposure_controller_if #(
  parameter int NUM_ROWS = 2,
  parameter int EXP_W    = 5
);
  logic                init;
  logic                continuous;
  logic                increase;
  logic                decrease;
  logic                erase;
  logic                expose;
  logic [NUM_ROWS-1:0] NRE;
  logic                ADC;
  logic                frame_done;
  logic                busy;
  logic [EXP_W-1:0]    exp_time;

  modport master (
    output init, continuous, increase, decrease,
    input  erase, expose, NRE, ADC, frame_done, busy, exp_time
  );

  modport slave (
    input  init, continuous, increase, decrease,
    output erase, expose, NRE, ADC, frame_done, busy, exp_time
  );
endinterface

// File: rtl/exposure_controller.sv
// Image-sensor exposure sequencer: IDLE (erase) -> EXPOSURE (exp_time cycles)
// -> READOUT (3 cycles per row, ADC strobe mid-row). Moore, registered outputs.
module exposure_controller #(
  parameter int NUM_ROWS = 2,
  parameter int EXP_W    = 5,
  parameter int EXP_MIN  = 2,
  parameter int EXP_MAX  = 30,
  parameter int EXP_INIT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  exposure_controller_if.slave bus
);

  localparam int CNT_W = (EXP_MAX > 1) ? $clog2(EXP_MAX) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {IDLE, EXPOSURE, READOUT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] exp_cnt, exp_cnt_n;
  logic [ROW_W-1:0] row, row_n;
  logic [1:0]       phase, phase_n;
  logic [EXP_W-1:0] exp_time_n;
  logic             start;

  function automatic logic [EXP_W-1:0] adjust_exp(input logic [EXP_W-1:0] t,
                                                   input logic inc,
                                                   input logic dec);
    adjust_exp = t;
    if (inc && !dec && (t < EXP_W'(EXP_MAX)))
      adjust_exp = t + EXP_W'(1);
    else if (dec && !inc && (t > EXP_W'(EXP_MIN)))
      adjust_exp = t - EXP_W'(1);
  endfunction

  function automatic logic [NUM_ROWS-1:0] nre_decode(input logic rd,
                                                     input logic [ROW_W-1:0] r);
    nre_decode = '1;
    if (rd) nre_decode[r] = 1'b0;
  endfunction

  // exp_time cannot change outside IDLE, so it already holds the value latched at entry
  always_comb begin
    state_n    = state;
    exp_cnt_n  = exp_cnt;
    row_n      = row;
    phase_n    = phase;
    exp_time_n = bus.exp_time;
    start      = bus.init | bus.continuous;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = EXPOSURE;
          exp_cnt_n = '0;
        end else begin
          exp_time_n = adjust_exp(bus.exp_time, bus.increase, bus.decrease);
        end
      end
      EXPOSURE: begin
        if (EXP_W'(exp_cnt) == (bus.exp_time - EXP_W'(1))) begin
          state_n = READOUT;
          row_n   = '0;
          phase_n = 2'd0;
        end else begin
          exp_cnt_n = exp_cnt + CNT_W'(1);
        end
      end
      READOUT: begin
        if (phase == 2'd2) begin
          phase_n = 2'd0;
          if (row == ROW_W'(NUM_ROWS - 1)) state_n = IDLE;
          else                             row_n   = row + ROW_W'(1);
        end else begin
          phase_n = phase + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs are registered from the decoded next state, so they line up with state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      exp_cnt        <= '0;
      row            <= '0;
      phase          <= 2'd0;
      bus.exp_time   <= EXP_W'(EXP_INIT);
      bus.erase      <= 1'b1;
      bus.expose     <= 1'b0;
      bus.NRE        <= '1;
      bus.ADC        <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_n;
      exp_cnt        <= exp_cnt_n;
      row            <= row_n;
      phase          <= phase_n;
      bus.exp_time   <= exp_time_n;
      bus.erase      <= (state_n == IDLE);
      bus.expose     <= (state_n == EXPOSURE);
      bus.busy       <= (state_n != IDLE);
      bus.NRE        <= nre_decode(state_n == READOUT, row_n);
      bus.ADC        <= (state_n == READOUT) && (phase_n == 2'd1);
      bus.frame_done <= (state_n == READOUT) && (phase_n == 2'd2) &&
                        (row_n == ROW_W'(NUM_ROWS - 1));
    end
  end

endmodule

// File: tb/tb_exposure_controller.sv
// Directed bench for exposure_controller: default 2-row instance plus a
// 4-row / 6-bit instance for wider readout and saturation.
module tb_exposure_controller;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  exposure_controller_if #(.NUM_ROWS(2), .EXP_W(5)) bus_a ();
  exposure_controller_if #(.NUM_ROWS(4), .EXP_W(6)) bus_b ();

  exposure_controller dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  exposure_controller #(
    .NUM_ROWS (4),
    .EXP_W    (6),
    .EXP_MIN  (2),
    .EXP_MAX  (60),
    .EXP_INIT (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] nre_a [6];
  logic [3:0] nre_b;
  int         adc_cnt;

  initial begin
    errors = 0;
    checks = 0;
    nre_a  = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    reset  = 1'b1;
    bus_a.init = 1'b0; bus_a.continuous = 1'b0; bus_a.increase = 1'b0; bus_a.decrease = 1'b0;
    bus_b.init = 1'b0; bus_b.continuous = 1'b0; bus_b.increase = 1'b0; bus_b.decrease = 1'b0;
    #12;
    chk("rst_erase",    32'(bus_a.erase),      32'd1);
    chk("rst_expose",   32'(bus_a.expose),     32'd0);
    chk("rst_nre",      32'(bus_a.NRE),        32'h3);
    chk("rst_adc",      32'(bus_a.ADC),        32'd0);
    chk("rst_busy",     32'(bus_a.busy),       32'd0);
    chk("rst_fd",       32'(bus_a.frame_done), 32'd0);
    chk("rst_exp_time", 32'(bus_a.exp_time),   32'd2);
    @(posedge clk);
    #1 reset = 1'b0;

    // single frame, exp_time=2
    bus_a.init = 1'b1;
    tick();
    bus_a.init = 1'b0;
    chk("f1_expose_c1", 32'(bus_a.expose), 32'd1);
    chk("f1_busy_c1",   32'(bus_a.busy),   32'd1);
    chk("f1_erase_c1",  32'(bus_a.erase),  32'd0);
    tick();
    chk("f1_expose_c2", 32'(bus_a.expose), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("f1_nre_%0d", i), 32'(bus_a.NRE),        32'(nre_a[i]));
      chk($sformatf("f1_adc_%0d", i), 32'(bus_a.ADC),        32'(i % 3 == 1));
      chk($sformatf("f1_fd_%0d", i),  32'(bus_a.frame_done), 32'(i == 5));
      chk($sformatf("f1_exp_%0d", i), 32'(bus_a.expose),     32'd0);
    end
    tick();
    chk("f1_idle_erase", 32'(bus_a.erase),      32'd1);
    chk("f1_idle_busy",  32'(bus_a.busy),       32'd0);
    chk("f1_idle_fd",    32'(bus_a.frame_done), 32'd0);

    // init held: new frame after exactly one IDLE cycle
    bus_a.init = 1'b1;
    repeat (8) tick();
    chk("hold_fd",     32'(bus_a.frame_done), 32'd1);
    tick();
    chk("hold_erase",  32'(bus_a.erase),      32'd1);
    chk("hold_busy",   32'(bus_a.busy),       32'd0);
    tick();
    chk("hold_expose", 32'(bus_a.expose),     32'd1);
    bus_a.init = 1'b0;
    repeat (8) tick();
    chk("hold_end_erase", 32'(bus_a.erase), 32'd1);

    // exposure-time adjustment in IDLE
    bus_a.increase = 1'b1;
    repeat (3) tick();
    chk("inc3", 32'(bus_a.exp_time), 32'd5);
    bus_a.decrease = 1'b1;
    repeat (4) tick();
    chk("both", 32'(bus_a.exp_time), 32'd5);
    bus_a.increase = 1'b0;
    repeat (10) tick();
    chk("dec_sat", 32'(bus_a.exp_time), 32'd2);
    bus_a.decrease = 1'b0;
    bus_a.increase = 1'b1;
    repeat (30) tick();
    chk("inc_sat", 32'(bus_a.exp_time), 32'd30);
    bus_a.increase = 1'b0;
    bus_a.decrease = 1'b1;
    repeat (27) tick();
    chk("dec27", 32'(bus_a.exp_time), 32'd3);
    bus_a.decrease = 1'b0;

    // increase ignored on the start edge and throughout the frame
    bus_a.increase = 1'b1;
    bus_a.init     = 1'b1;
    tick();
    bus_a.init = 1'b0;
    chk("incx_start",   32'(bus_a.exp_time), 32'd3);
    chk("incx_busy",    32'(bus_a.busy),     32'd1);
    repeat (9) tick();
    chk("incx_end",     32'(bus_a.exp_time), 32'd3);
    chk("incx_idle",    32'(bus_a.erase),    32'd1);
    bus_a.increase = 1'b0;

    // continuous mode, exp_time=3 -> period 10
    bus_a.continuous = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("cont_fd_%0d", k), 32'(bus_a.frame_done), 32'(k % 10 == 9));
    end
    tick();
    chk("cont_last_expose", 32'(bus_a.expose), 32'd1);
    bus_a.continuous = 1'b0;
    repeat (8) tick();
    chk("cont_last_fd", 32'(bus_a.frame_done), 32'd1);
    tick();
    chk("cont_stop_erase", 32'(bus_a.erase), 32'd1);
    chk("cont_stop_busy",  32'(bus_a.busy),  32'd0);
    repeat (3) tick();
    chk("cont_stay_erase", 32'(bus_a.erase), 32'd1);
    chk("cont_stay_busy",  32'(bus_a.busy),  32'd0);

    // asynchronous reset in the middle of readout
    bus_a.init = 1'b1;
    tick();
    bus_a.init = 1'b0;
    repeat (4) tick();
    chk("mid_adc", 32'(bus_a.ADC), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_nre",   32'(bus_a.NRE),      32'h3);
    chk("arst_adc",   32'(bus_a.ADC),      32'd0);
    chk("arst_erase", 32'(bus_a.erase),    32'd1);
    chk("arst_busy",  32'(bus_a.busy),     32'd0);
    chk("arst_exp",   32'(bus_a.exp_time), 32'd2);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("no_resume_erase", 32'(bus_a.erase), 32'd1);
    tick();
    chk("no_resume_busy",  32'(bus_a.busy),  32'd0);

    // 4-row instance
    bus_b.init = 1'b1;
    tick();
    bus_b.init = 1'b0;
    chk("b_expose", 32'(bus_b.expose), 32'd1);
    tick();
    adc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nre_b = 4'b1111 ^ (4'b0001 << (i / 3));
      if (bus_b.ADC === 1'b1) adc_cnt++;
      chk($sformatf("b_nre_%0d", i), 32'(bus_b.NRE),        32'(nre_b));
      chk($sformatf("b_adc_%0d", i), 32'(bus_b.ADC),        32'(i % 3 == 1));
      chk($sformatf("b_fd_%0d", i),  32'(bus_b.frame_done), 32'(i == 11));
    end
    chk("b_adc_count", 32'(adc_cnt), 32'd4);
    tick();
    chk("b_idle_erase", 32'(bus_b.erase), 32'd1);
    bus_b.increase = 1'b1;
    repeat (65) tick();
    chk("b_inc_sat", 32'(bus_b.exp_time), 32'd60);
    bus_b.increase = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
